// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller driving PC, IF/ID, ID/EX and EX/MEM controls
// Optional macro HAZARD_MDU_EN enables the MDU_WAIT freeze for multi-cycle mult/div.
module hazard_ctrl #(
  parameter int RESET_HOLD  = 2,
  parameter int MDU_LATENCY = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_idexMemRead,
  input  logic [4:0] i_idexRt,
  input  logic [4:0] i_ifidRs,
  input  logic [4:0] i_ifidRt,
  input  logic       i_branchTaken,
  input  logic       i_mduStart,
  output logic       o_pcWrite,
  output logic       o_ifidWrite,
  output logic       o_ifidFlush,
  output logic       o_idexWrite,
  output logic       o_idexFlush,
  output logic       o_exmemFlush,
  output logic [1:0] o_state
);

  localparam int CNT_MAX = (RESET_HOLD > MDU_LATENCY) ? RESET_HOLD : MDU_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(RESET_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_MDU_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

`ifdef HAZARD_MDU_EN
  localparam logic [CNT_W-1:0] CNT_MDU = CNT_W'(MDU_LATENCY - 1);
  logic idex_write;
  logic exmem_flush;
  assign o_idexWrite  = idex_write;
  assign o_exmemFlush = exmem_flush;
`else
  assign o_idexWrite  = 1'b1;
  assign o_exmemFlush = 1'b0;
  wire unused_mdu = i_mduStart;
`endif

  // Register $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = i_idexMemRead && (i_idexRt != 5'd0) &&
                    ((i_idexRt == i_ifidRs) || (i_idexRt == i_ifidRt));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_HOLD;
      cnt   <= CNT_HOLD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    o_pcWrite   = 1'b1;
    o_ifidWrite = 1'b1;
    o_ifidFlush = 1'b0;
    o_idexFlush = 1'b0;
`ifdef HAZARD_MDU_EN
    idex_write  = 1'b1;
    exmem_flush = 1'b0;
`endif
    case (state)
      S_HOLD: begin
        o_pcWrite   = 1'b0;
        o_ifidWrite = 1'b0;
        o_ifidFlush = 1'b1;
        o_idexFlush = 1'b1;
        cnt_nxt     = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_branchTaken) begin
          // Squash the two wrong-path instructions; the branch outranks any stall.
          o_ifidFlush = 1'b1;
          o_idexFlush = 1'b1;
`ifdef HAZARD_MDU_EN
        end else if (i_mduStart) begin
          state_nxt = S_MDU_WAIT;
          cnt_nxt   = CNT_MDU;
`endif
        end else if (load_use) begin
          o_pcWrite   = 1'b0;
          o_ifidWrite = 1'b0;
          o_idexFlush = 1'b1;
        end
      end
`ifdef HAZARD_MDU_EN
      S_MDU_WAIT: begin
        // Freeze everything upstream of EX and keep EX/MEM empty until the MDU finishes.
        o_pcWrite   = 1'b0;
        o_ifidWrite = 1'b0;
        idex_write  = 1'b0;
        exmem_flush = 1'b1;
        cnt_nxt     = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_RUN;
      end
`endif
      default: begin
        state_nxt = S_HOLD;
        cnt_nxt   = CNT_HOLD;
      end
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl (RESET_HOLD=2, MDU_LATENCY=4)
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] idex_rt = '0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;
  logic       branch = 1'b0;
  logic       mdu_start = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemFlush, state[1:0]}
  localparam logic [7:0] E_HOLD  = 8'b0011_1000;
  localparam logic [7:0] E_RUN   = 8'b1101_0001;
  localparam logic [7:0] E_STALL = 8'b0001_1001;
  localparam logic [7:0] E_BR    = 8'b1111_1001;
  localparam logic [7:0] E_WAIT  = 8'b0000_0110;

  hazard_ctrl #(.RESET_HOLD(2), .MDU_LATENCY(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_idexMemRead (mem_read),
    .i_idexRt      (idex_rt),
    .i_ifidRs      (ifid_rs),
    .i_ifidRt      (ifid_rt),
    .i_branchTaken (branch),
    .i_mduStart    (mdu_start),
    .o_pcWrite     (pc_write),
    .o_ifidWrite   (ifid_write),
    .o_ifidFlush   (ifid_flush),
    .o_idexWrite   (idex_write),
    .o_idexFlush   (idex_flush),
    .o_exmemFlush  (exmem_flush),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mem_read;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       branch;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic m, input logic [4:0] d, input logic [4:0] s,
                              input logic [4:0] t, input logic b, input logic [7:0] e,
                              input string n);
    vec_t v;
    v.mem_read = m; v.idex_rt = d; v.rs = s; v.rt = t; v.branch = b; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, state};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0; branch = 1'b0; mdu_start = 1'b0;
  endtask

  // Called with rst high; releases on a falling edge and walks the two HOLD edges.
  task automatic release_seq(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1 check({tag, "_hold0"}, E_HOLD);
    @(negedge clk);
    #1 check({tag, "_hold1"}, E_HOLD);
    @(negedge clk);
    #1 check({tag, "_run"}, E_RUN);
  endtask

  initial begin
    vecs[0] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RUN,   "idle");
    vecs[1] = mk(1'b1, 5'd5,  5'd5,  5'd3,  1'b0, E_STALL, "lu_rs");
    vecs[2] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RUN,   "lu_cleared");
    vecs[3] = mk(1'b1, 5'd7,  5'd2,  5'd7,  1'b0, E_STALL, "lu_rt");
    vecs[4] = mk(1'b1, 5'd0,  5'd0,  5'd0,  1'b0, E_RUN,   "lu_reg0");
    vecs[5] = mk(1'b0, 5'd5,  5'd5,  5'd5,  1'b0, E_RUN,   "no_load");
    vecs[6] = mk(1'b1, 5'd9,  5'd8,  5'd10, 1'b0, E_RUN,   "no_match");
    vecs[7] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b1, E_BR,    "branch");
    vecs[8] = mk(1'b1, 5'd31, 5'd31, 5'd1,  1'b1, E_BR,    "branch_lu");

    @(negedge clk);
    #1 check("rst_state", E_HOLD);
    release_seq("init");

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_read = vecs[i].mem_read;
      idex_rt  = vecs[i].idex_rt;
      ifid_rs  = vecs[i].rs;
      ifid_rt  = vecs[i].rt;
      branch   = vecs[i].branch;
      #1 check(vecs[i].name, vecs[i].exp);
    end
    @(negedge clk);
    clear_inputs();
    #1 check("after_table", E_RUN);

    // Asynchronous reset mid-cycle while running
    #2 rst = 1'b1;
    #1 check("rst_async", E_HOLD);
    release_seq("mid");

`ifdef HAZARD_MDU_EN
    @(negedge clk);
    mdu_start = 1'b1; mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 check("mdu_start", E_RUN);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mdu_start = 1'b0;
      #1 check($sformatf("mdu_wait%0d", i), E_WAIT);
    end
    @(negedge clk);
    clear_inputs();
    mdu_start = 1'b1;
    #1 check("mdu_resume", E_RUN);
    @(negedge clk);
    mdu_start = 1'b0;
    #1 check("mdu_restart", E_WAIT);
    @(negedge clk);
    #1 check("mdu_wait_2nd", E_WAIT);
    #2 rst = 1'b1;
    #1 check("rst_in_wait", E_HOLD);
    release_seq("mdu");
`else
    @(negedge clk);
    mdu_start = 1'b1;
    #1 check("mdu_off_start", E_RUN);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mdu_start = 1'b0;
      #1 check($sformatf("mdu_off%0d", i), E_RUN);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
